// File: rtl/sobel_mmio_ctrl_if.sv
// Single-beat MMIO request/response bus between the user-domain crossbar and
// the Sobel control front end.
interface sobel_mmio_ctrl_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/sobel_mmio_ctrl.sv
// Control/status front end for the Sobel accelerator: register decode, start
// pulse generation, completion capture, run counters and level interrupt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no run outstanding; a CTRL go write launches the accelerator
// ST_BUSY | start issued, waiting for the accel_done rising edge
module sobel_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_mmio_ctrl_if.slave  bus,
    output logic              accel_start,
    input  logic              accel_done,
    input  logic              accel_match,
    output logic              irq
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h01;
    localparam logic [7:0] OFF_RUN    = 8'h02;
    localparam logic [7:0] OFF_MATCH  = 8'h03;

    state_t             state;
    state_t             state_nxt;

    logic [7:0]         off;
    logic               mapped;
    logic               wr_ctrl;
    logic               wr_status;
    logic               wr_clr;
    logic               go_fire;
    logic               busy;

    logic               done_q;
    logic               done_edge;
    logic               irq_en;
    logic               done_sticky;
    logic               match_latched;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   match_cnt;
    logic [CNT_W-1:0]   run_inc;
    logic [CNT_W-1:0]   match_inc;
    logic [31:0]        rd_mux;

    logic               unused_bits;

    assign unused_bits = ^{bus.addr[31:10], bus.addr[1:0], bus.wdata[31:2], BASE_ADDR};

    assign off       = bus.addr[9:2];
    assign mapped    = (off == OFF_CTRL) || (off == OFF_STATUS) ||
                       (off == OFF_RUN)  || (off == OFF_MATCH);
    assign wr_ctrl   = bus.req && bus.we && (off == OFF_CTRL);
    assign wr_status = bus.req && bus.we && (off == OFF_STATUS);
    assign wr_clr    = bus.req && bus.we && (off == OFF_MATCH);

    assign bus.gnt   = bus.req;

    assign done_edge = accel_done && !done_q;
    assign run_inc   = {{(CNT_W-1){1'b0}}, done_edge};
    assign match_inc = {{(CNT_W-1){1'b0}}, done_edge && accel_match};

    assign irq       = done_sticky && irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // busy is the registered state, so a go landing with the done edge is ignored
    always_comb begin
        state_nxt = state;
        go_fire   = 1'b0;
        busy      = (state == ST_BUSY);
        case (state)
            ST_IDLE: begin
                if (wr_ctrl && bus.wdata[0]) begin
                    go_fire   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_edge) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q        <= 1'b0;
            accel_start   <= 1'b0;
            irq_en        <= 1'b0;
            done_sticky   <= 1'b0;
            match_latched <= 1'b0;
        end else begin
            done_q      <= accel_done;
            accel_start <= go_fire;
            if (wr_ctrl) begin
                irq_en <= bus.wdata[1];
            end
            // completion has priority over both the go clear and W1C
            if (done_edge) begin
                done_sticky <= 1'b1;
            end else if (go_fire) begin
                done_sticky <= 1'b0;
            end else if (wr_status && bus.wdata[1]) begin
                done_sticky <= 1'b0;
            end
            if (done_edge) begin
                match_latched <= accel_match;
            end else if (go_fire) begin
                match_latched <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            match_cnt <= '0;
        end else if (wr_clr) begin
            run_cnt   <= run_inc;
            match_cnt <= match_inc;
        end else begin
            run_cnt   <= run_cnt + run_inc;
            match_cnt <= match_cnt + match_inc;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (off)
            OFF_CTRL:   rd_mux = {30'd0, irq_en, 1'b0};
            OFF_STATUS: rd_mux = {29'd0, match_latched, done_sticky, busy};
            OFF_RUN:    rd_mux = 32'(run_cnt);
            OFF_MATCH:  rd_mux = 32'(match_cnt);
            default:    rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= 32'd0;
            bus.err    <= 1'b0;
        end else begin
            bus.rvalid <= bus.req;
            bus.rdata  <= (bus.req && !bus.we) ? rd_mux : 32'd0;
            bus.err    <= bus.req && !mapped;
        end
    end

endmodule

// File: tb/tb_sobel_mmio_ctrl.sv
// Bench for sobel_mmio_ctrl: directed scenarios plus a random operation mix,
// checked against a register-level model of the control block.
module tb_sobel_mmio_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic accel_done = 1'b0;
    logic accel_match = 1'b0;
    logic accel_start;
    logic irq;

    sobel_mmio_ctrl_if bus();

    sobel_mmio_ctrl #(.BASE_ADDR(32'h2000_0000), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .accel_start (accel_start),
        .accel_done  (accel_done),
        .accel_match (accel_match),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int exp_starts = 0;

    bit m_busy, m_done, m_match, m_irq_en;
    int m_run, m_mcnt;

    always @(posedge clk) if (accel_start === 1'b1) start_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(int off);
        case (off)
            0: return {30'd0, m_irq_en, 1'b0};
            1: return {29'd0, m_match, m_done, m_busy};
            2: return 32'(m_run);
            3: return 32'(m_mcnt);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_match = 0; m_irq_en = 0; m_run = 0; m_mcnt = 0;
    endtask

    task automatic model_write(int off, logic [31:0] d, output bit fire);
        fire = 0;
        case (off)
            0: begin
                fire = d[0] && !m_busy;
                if (fire) begin m_busy = 1; m_done = 0; m_match = 0; exp_starts++; end
                m_irq_en = d[1];
            end
            1: if (d[1]) m_done = 0;
            3: begin m_run = 0; m_mcnt = 0; end
            default: ;
        endcase
    endtask

    task automatic model_done(bit m);
        m_busy = 0; m_done = 1; m_match = m;
        m_run = (m_run + 1) % 65536;
        if (m) m_mcnt = (m_mcnt + 1) % 65536;
    endtask

    function automatic logic [31:0] make_addr(int off);
        logic [31:0] a;
        a = $urandom();
        a[9:2] = off[7:0];
        return a;
    endfunction

    // Called at a falling edge; returns at the falling edge after the response.
    task automatic bus_op(bit w, int off, logic [31:0] d, string tag);
        logic [31:0] exp_rd;
        bit exp_err, fire;
        exp_rd  = w ? 32'd0 : model_read(off);
        exp_err = (off > 3);
        bus.req = 1; bus.we = w; bus.addr = make_addr(off); bus.wdata = d;
        #1 chk($sformatf("%s.gnt", tag), {31'd0, bus.gnt}, 32'd1);
        @(negedge clk);
        bus.req = 0; bus.we = 0;
        chk($sformatf("%s.rvalid", tag), {31'd0, bus.rvalid}, 32'd1);
        chk($sformatf("%s.rdata", tag), bus.rdata, exp_rd);
        chk($sformatf("%s.err", tag), {31'd0, bus.err}, {31'd0, exp_err});
        fire = 0;
        if (w) model_write(off, d, fire);
        chk($sformatf("%s.start", tag), {31'd0, accel_start}, {31'd0, fire});
        chk($sformatf("%s.irq", tag), {31'd0, irq}, {31'd0, m_done & m_irq_en});
    endtask

    task automatic done_pulse(bit m, int hold);
        accel_done = 1; accel_match = m;
        repeat (hold) @(negedge clk);
        accel_done = 0; accel_match = 1'($urandom());
        model_done(m);
        @(negedge clk);
        chk("done.irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
        chk("done.start", {31'd0, accel_start}, 32'd0);
    endtask

    // Write accepted in the same cycle as a done rising edge.
    task automatic write_with_done(int off, logic [31:0] d, bit m, string tag);
        bit fire;
        bus.req = 1; bus.we = 1; bus.addr = make_addr(off); bus.wdata = d;
        accel_done = 1; accel_match = m;
        @(negedge clk);
        bus.req = 0; bus.we = 0; accel_done = 0;
        model_write(off, d, fire);
        model_done(m);
        chk($sformatf("%s.err", tag), {31'd0, bus.err}, 32'd0);
        chk($sformatf("%s.start", tag), {31'd0, accel_start}, {31'd0, fire});
        @(negedge clk);
    endtask

    initial begin
        int op, off;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("rst.start", {31'd0, accel_start}, 32'd0);
        chk("rst.irq", {31'd0, irq}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) bus_op(0, i, 0, "rst_rd");

        bus_op(1, 0, 32'h3, "go1");
        bus_op(0, 1, 0, "busy_rd");
        done_pulse(1, 2);
        chk("irq_after_done", {31'd0, irq}, 32'd1);
        for (int i = 1; i < 4; i++) bus_op(0, i, 0, "run1_rd");

        bus_op(1, 1, 32'h2, "w1c");
        bus_op(0, 1, 0, "w1c_rd");

        bus_op(1, 0, 32'h1, "go2a");
        bus_op(1, 0, 32'h1, "go2b");
        done_pulse(0, 1);
        bus_op(0, 2, 0, "run2_rd");
        bus_op(0, 3, 0, "mcnt2_rd");
        chk("one_pulse", 32'(start_cnt), 32'(exp_starts));

        bus_op(0, 4, 0, "unmap_rd");
        bus_op(1, 8, 32'hFFFF_FFFF, "unmap_wr");
        bus_op(1, 2, 32'h1234, "ro_wr");
        bus_op(0, 2, 0, "ro_rd");

        force dut.run_cnt = 16'hFFFF;
        force dut.match_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.run_cnt;
        release dut.match_cnt;
        m_run = 65535; m_mcnt = 65535;
        bus_op(0, 2, 0, "pre_wrap_rd");
        done_pulse(1, 1);
        bus_op(0, 2, 0, "wrap_run_rd");
        bus_op(0, 3, 0, "wrap_mcnt_rd");

        write_with_done(1, 32'h2, 1, "w1c_vs_done");
        bus_op(0, 1, 0, "w1c_vs_done_rd");
        write_with_done(3, 32'h0, 1, "clr_vs_done");
        bus_op(0, 2, 0, "clr_run_rd");
        bus_op(0, 3, 0, "clr_mcnt_rd");
        write_with_done(3, 32'h0, 0, "clr_vs_done0");
        bus_op(0, 3, 0, "clr_mcnt0_rd");

        bus_op(1, 0, 32'h1, "go3");
        write_with_done(0, 32'h3, 0, "go_vs_done");
        bus_op(0, 1, 0, "go_vs_done_rd");
        bus_op(0, 0, 0, "go_vs_done_ctrl");

        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                off = $urandom_range(0, 5);
                if (off >= 4) off = $urandom_range(4, 255);
                bus_op(0, off, 0, "rnd_rd");
            end else if (op <= 5) begin
                bus_op(1, 0, $urandom(), "rnd_ctrl");
            end else if (op == 6) begin
                bus_op(1, 1, $urandom(), "rnd_status");
            end else if (op == 7) begin
                off = ($urandom_range(0, 3) == 0) ? 3 : $urandom_range(4, 255);
                bus_op(1, off, $urandom(), "rnd_wr");
            end else begin
                done_pulse(1'($urandom_range(0, 1)), $urandom_range(1, 3));
            end
        end

        done_pulse(0, 1);
        bus_op(1, 0, 32'h1, "go4");
        bus_op(0, 1, 0, "go4_rd");
        bus.req = 1; bus.we = 0; bus.addr = make_addr(1);
        #2 rst_n = 0;
        #1;
        chk("arst.rvalid", {31'd0, bus.rvalid}, 32'd0);
        chk("arst.rdata", bus.rdata, 32'd0);
        chk("arst.err", {31'd0, bus.err}, 32'd0);
        chk("arst.start", {31'd0, accel_start}, 32'd0);
        chk("arst.irq", {31'd0, irq}, 32'd0);
        chk("arst.gnt", {31'd0, bus.gnt}, 32'd1);
        @(negedge clk);
        chk("arst.no_resp", {31'd0, bus.rvalid}, 32'd0);
        bus.req = 0;
        model_reset();
        rst_n = 1;
        @(negedge clk);
        bus_op(0, 1, 0, "post_rst_status");
        bus_op(0, 2, 0, "post_rst_run");
        bus_op(1, 0, 32'h1, "post_rst_go");
        bus_op(0, 1, 0, "post_rst_busy");

        repeat (3) @(negedge clk);
        chk("start_total", 32'(start_cnt), 32'(exp_starts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
